// File: rtl/cube_edge_sched.sv
// Cube wireframe edge scheduler: walks a fixed 9-edge table over 7 programmable
// vertices, hands each edge to a line engine and waits for its completion.
//
// state | meaning
// IDLE  | waiting for frame_start, vertex writes accepted
// LOAD  | latch endpoints of edge_idx from the vertex registers
// START | pulse eng_start, clear the wait counter
// WAIT  | wait for eng_done or the wait counter to reach TIMEOUT
// NEXT  | advance to the next edge or finish the pass
// DONE  | pulse frame_done, back to IDLE
module cube_edge_sched #(
    parameter int NUM_EDGES = 9,
    parameter int TIMEOUT   = 4095
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        frame_start_i,
    input  logic        cfg_we_i,
    input  logic [2:0]  cfg_addr_i,
    input  logic [20:0] cfg_data_i,
    input  logic        eng_done_i,
    output logic        eng_start_o,
    output logic [10:0] eng_x0_o,
    output logic [10:0] eng_x1_o,
    output logic [9:0]  eng_y0_o,
    output logic [9:0]  eng_y1_o,
    output logic [3:0]  edge_idx_o,
    output logic        busy_o,
    output logic        frame_done_o,
    output logic        overrun_o,
    output logic        timeout_err_o,
    output logic        cfg_err_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_NEXT  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [3:0]  LAST_EDGE   = 4'(NUM_EDGES - 1);
    localparam logic [11:0] TIMEOUT_CNT = 12'(TIMEOUT);

    logic [2:0]  state_q, state_d;
    logic [3:0]  edge_idx_q, edge_idx_d;
    logic [11:0] wait_cnt_q, wait_cnt_d;
    logic [10:0] eng_x0_q, eng_x0_d, eng_x1_q, eng_x1_d;
    logic [9:0]  eng_y0_q, eng_y0_d, eng_y1_q, eng_y1_d;
    logic        eng_start_q, eng_start_d;
    logic        busy_q, busy_d;
    logic        frame_done_q, frame_done_d;
    logic        overrun_q, overrun_d;
    logic        timeout_err_q, timeout_err_d;
    logic        cfg_err_q, cfg_err_d;
    logic [20:0] vert_q [7];
    logic [2:0]  sv, ev;

    always_comb begin
        sv = 3'd0;
        ev = 3'd1;
        case (edge_idx_q)
            4'd0: begin sv = 3'd0; ev = 3'd1; end
            4'd1: begin sv = 3'd1; ev = 3'd2; end
            4'd2: begin sv = 3'd2; ev = 3'd3; end
            4'd3: begin sv = 3'd3; ev = 3'd4; end
            4'd4: begin sv = 3'd5; ev = 3'd4; end
            4'd5: begin sv = 3'd0; ev = 3'd5; end
            4'd6: begin sv = 3'd0; ev = 3'd6; end
            4'd7: begin sv = 3'd6; ev = 3'd4; end
            4'd8: begin sv = 3'd6; ev = 3'd2; end
            default: begin sv = 3'd0; ev = 3'd1; end
        endcase
    end

    always_comb begin
        state_d       = state_q;
        edge_idx_d    = edge_idx_q;
        wait_cnt_d    = wait_cnt_q;
        eng_x0_d      = eng_x0_q;
        eng_y0_d      = eng_y0_q;
        eng_x1_d      = eng_x1_q;
        eng_y1_d      = eng_y1_q;
        eng_start_d   = 1'b0;
        frame_done_d  = 1'b0;
        timeout_err_d = 1'b0;
        overrun_d     = frame_start_i && (state_q != S_IDLE);
        cfg_err_d     = cfg_we_i && ((state_q != S_IDLE) || (cfg_addr_i == 3'd7));
        case (state_q)
            S_IDLE: begin
                if (frame_start_i) begin
                    state_d    = S_LOAD;
                    edge_idx_d = 4'd0;
                end
            end
            S_LOAD: begin
                eng_x0_d = vert_q[sv][20:10];
                eng_y0_d = vert_q[sv][9:0];
                eng_x1_d = vert_q[ev][20:10];
                eng_y1_d = vert_q[ev][9:0];
                state_d  = S_START;
            end
            S_START: begin
                eng_start_d = 1'b1;
                wait_cnt_d  = 12'd0;
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                // completion wins over a timeout landing in the same cycle
                if (eng_done_i) begin
                    state_d = S_NEXT;
                end else if (wait_cnt_q == TIMEOUT_CNT) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_NEXT;
                end else begin
                    wait_cnt_d = wait_cnt_q + 12'd1;
                end
            end
            S_NEXT: begin
                if (edge_idx_q == LAST_EDGE) begin
                    state_d = S_DONE;
                end else begin
                    edge_idx_d = edge_idx_q + 4'd1;
                    state_d    = S_LOAD;
                end
            end
            S_DONE: begin
                frame_done_d = 1'b1;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= S_IDLE;
            edge_idx_q    <= 4'd0;
            wait_cnt_q    <= 12'd0;
            eng_x0_q      <= 11'd0;
            eng_y0_q      <= 10'd0;
            eng_x1_q      <= 11'd0;
            eng_y1_q      <= 10'd0;
            eng_start_q   <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            overrun_q     <= 1'b0;
            timeout_err_q <= 1'b0;
            cfg_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            edge_idx_q    <= edge_idx_d;
            wait_cnt_q    <= wait_cnt_d;
            eng_x0_q      <= eng_x0_d;
            eng_y0_q      <= eng_y0_d;
            eng_x1_q      <= eng_x1_d;
            eng_y1_q      <= eng_y1_d;
            eng_start_q   <= eng_start_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
            overrun_q     <= overrun_d;
            timeout_err_q <= timeout_err_d;
            cfg_err_q     <= cfg_err_d;
        end
    end

    // Vertex registers reset to the default cube outline
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            vert_q[0] <= {11'd400, 10'd300};
            vert_q[1] <= {11'd520, 10'd300};
            vert_q[2] <= {11'd570, 10'd390};
            vert_q[3] <= {11'd520, 10'd480};
            vert_q[4] <= {11'd400, 10'd480};
            vert_q[5] <= {11'd350, 10'd390};
            vert_q[6] <= {11'd450, 10'd390};
        end else if (cfg_we_i && (state_q == S_IDLE) && (cfg_addr_i != 3'd7)) begin
            vert_q[cfg_addr_i] <= cfg_data_i;
        end
    end

    assign eng_start_o   = eng_start_q;
    assign eng_x0_o      = eng_x0_q;
    assign eng_y0_o      = eng_y0_q;
    assign eng_x1_o      = eng_x1_q;
    assign eng_y1_o      = eng_y1_q;
    assign edge_idx_o    = edge_idx_q;
    assign busy_o        = busy_q;
    assign frame_done_o  = frame_done_q;
    assign overrun_o     = overrun_q;
    assign timeout_err_o = timeout_err_q;
    assign cfg_err_o     = cfg_err_q;

endmodule
